// File: rtl/axis_crc32_checker.sv
// ---------------------------------------------------------------------------
// axis_crc32_checker
//
// Receive-side CRC-32 (Ethernet FCS) checker for a byte-wide AXI4-Stream.
// Each frame arrives as payload followed by the 4 FCS bytes. The block
// forwards the payload, removes the FCS, flags the last payload beat with a
// pass/fail bit, and reports per-frame status.
//
// The FCS is removed by holding the four most recent bytes in a delay line.
// A byte is released downstream only once four newer bytes have arrived.
// When the frame ends, the four bytes still in the line are the FCS and are
// discarded.
//
// Ports
//   aclk_0, aresetn_0   clock (rising edge), asynchronous active-low reset
//   s_axis_*            upstream byte stream; tlast marks the last FCS byte
//   m_axis_*            payload stream; tlast on the last payload byte,
//                       tuser=1 with tlast when the CRC does not match
//   frame_done          one-cycle pulse per consumed input frame
//   crc_err, runt       frame status, qualified by frame_done
//   err_count           saturating count of frames with crc_err or runt
// ---------------------------------------------------------------------------
module axis_crc32_checker #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 aclk_0,
    input  logic                 aresetn_0,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 frame_done,
    output logic                 crc_err,
    output logic                 runt,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    // Register value left after a frame whose FCS bytes are correct.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Reflected CRC-32: one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Delay line: entry 0 is the oldest byte.
    logic [3:0][7:0]        dl_q, dl_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [31:0]            crc_q, crc_d;
    logic [7:0]             odata_q, odata_d;
    logic                   ovalid_q, ovalid_d;
    logic                   olast_q, olast_d;
    logic                   ouser_q, ouser_d;
    logic                   done_q, done_d;
    logic                   cerr_q, cerr_d;
    logic                   runt_q, runt_d;
    logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d;
    // Holds tready low while in reset and until the first clock afterwards.
    logic                   alive_q;

    logic        line_full;
    logic        accept;
    logic        mismatch;
    logic [31:0] crc_next;

    assign line_full     = (cnt_q == 3'd4);
    // A full line can only accept a beat if the output register can take the
    // byte being pushed out.
    assign s_axis_tready = alive_q & (!line_full | !ovalid_q | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign crc_next      = crc_byte(crc_q, s_axis_tdata);
    // Includes the byte being accepted now.
    assign mismatch      = (crc_next != CRC_RESIDUE);

    always_comb begin
        dl_d     = dl_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        ouser_d  = ouser_q;
        done_d   = 1'b0;
        cerr_d   = 1'b0;
        runt_d   = 1'b0;

        // The downstream side took the beat; the register empties unless
        // it is reloaded below.
        if (ovalid_q && m_axis_tready) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
            ouser_d  = 1'b0;
        end

        if (accept) begin
            // The oldest byte leaves only when the line is full.
            // s_axis_tready guarantees the output register is free.
            if (line_full) begin
                odata_d  = dl_q[0];
                ovalid_d = 1'b1;
                olast_d  = s_axis_tlast;
                ouser_d  = s_axis_tlast & mismatch;
            end

            if (s_axis_tlast) begin
                // End of frame. The remaining 4 bytes are the FCS, or the
                // whole frame if it is a runt. Either way they are dropped.
                dl_d   = '0;
                cnt_d  = 3'd0;
                crc_d  = CRC_INIT;
                done_d = 1'b1;
                cerr_d = line_full & mismatch;
                runt_d = !line_full;
            end else begin
                crc_d = crc_next;
                if (line_full) begin
                    dl_d = {s_axis_tdata, dl_q[3:1]};
                end else begin
                    dl_d[cnt_q[1:0]] = s_axis_tdata;
                    cnt_d            = cnt_q + 3'd1;
                end
            end
        end
    end

    // The counter follows the registered status, so its new value shows
    // one cycle after the frame_done pulse.
    always_comb begin
        errcnt_d = errcnt_q;
        if (done_q && (cerr_q || runt_q) && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            dl_q     <= '0;
            cnt_q    <= 3'd0;
            crc_q    <= CRC_INIT;
            odata_q  <= 8'd0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            ouser_q  <= 1'b0;
            done_q   <= 1'b0;
            cerr_q   <= 1'b0;
            runt_q   <= 1'b0;
            errcnt_q <= '0;
            alive_q  <= 1'b0;
        end else begin
            dl_q     <= dl_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            ouser_q  <= ouser_d;
            done_q   <= done_d;
            cerr_q   <= cerr_d;
            runt_q   <= runt_d;
            errcnt_q <= errcnt_d;
            alive_q  <= 1'b1;
        end
    end

    assign m_axis_tdata  = odata_q;
    assign m_axis_tvalid = ovalid_q;
    assign m_axis_tlast  = olast_q;
    assign m_axis_tuser  = ouser_q;
    assign frame_done    = done_q;
    assign crc_err       = cerr_q;
    assign runt          = runt_q;
    assign err_count     = errcnt_q;

endmodule

// File: tb/tb_axis_crc32_checker.sv
// ---------------------------------------------------------------------------
// Bench for axis_crc32_checker. Two instances share the input stream:
// dut uses the default counter width, and dut2 uses ERR_CNT_W=2 so the
// saturation case can be observed. The reference model computes the
// standard CRC-32 of the payload with a byte table. It compares the result
// against the received FCS, then queues the expected payload beats and the
// expected frame status.
// ---------------------------------------------------------------------------
module tb_axis_crc32_checker;

    logic aclk_0 = 1'b0;
    always #5 aclk_0 = ~aclk_0;

    logic        aresetn_0;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic        frame_done, crc_err, runt;
    logic [15:0] err_count;

    logic        s_axis_tready2;
    logic [7:0]  m_axis_tdata2;
    logic        m_axis_tvalid2, m_axis_tlast2, m_axis_tuser2;
    logic        frame_done2, crc_err2, runt2;
    logic [1:0]  err_count2;

    axis_crc32_checker #(.ERR_CNT_W(16)) dut (
        .aclk_0(aclk_0), .aresetn_0(aresetn_0),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .frame_done(frame_done),
        .crc_err(crc_err), .runt(runt), .err_count(err_count)
    );

    axis_crc32_checker #(.ERR_CNT_W(2)) dut2 (
        .aclk_0(aclk_0), .aresetn_0(aresetn_0),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready2), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata2), .m_axis_tvalid(m_axis_tvalid2),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast2),
        .m_axis_tuser(m_axis_tuser2), .frame_done(frame_done2),
        .crc_err(crc_err2), .runt(runt2), .err_count(err_count2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       user;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  fbuf[64];
    int          flen;
    logic [31:0] crc_tab[256];
    int          exp_frames = 0;
    int          exp_cnt    = 0;
    int          exp_cnt2   = 0;

    task automatic build_tab();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = n;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
    endtask

    // Standard CRC-32 (final complement included) over fbuf[0..n-1].
    function automatic logic [31:0] crc32_std(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_tab[c[7:0] ^ fbuf[i]] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic model_frame(output logic e_err, output logic e_runt);
        logic [31:0] fcs;
        e_err  = 1'b0;
        e_runt = 1'b0;
        if (flen < 5) begin
            e_runt = 1'b1;
        end else begin
            fcs   = {fbuf[flen-1], fbuf[flen-2], fbuf[flen-3], fbuf[flen-4]};
            e_err = (fcs != crc32_std(flen - 4));
            for (int i = 0; i < flen - 4; i++)
                exp_q.push_back('{d: fbuf[i], last: (i == flen - 5), user: (i == flen - 5) && e_err});
        end
        exp_frames++;
        if (e_err || e_runt) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt2 < 3) exp_cnt2++;
        end
    endtask

    // ---------------- stimulus ----------------
    logic rand_rdy = 1'b0;
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk_0); #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) begin @(posedge aclk_0); #1; end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic last);
        int t = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge aclk_0);
            if (s_axis_tready) break;
            t++;
            if (t > 1000) begin
                errors++;
                $display("FAIL s_handshake_timeout: got no tready expected tready within 1000 cycles");
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "timeout");
            end
        end
        @(posedge aclk_0); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Sends fbuf[0..flen-1]. Returns the status outputs sampled one cycle
    // after the tlast handshake.
    task automatic send_frame(input int gap, output logic o_done, output logic o_err, output logic o_runt);
        for (int i = 0; i < flen; i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk_0); #1;
            end
            drive_byte(fbuf[i], i == flen - 1);
        end
        o_done = frame_done;
        o_err  = crc_err;
        o_runt = runt;
    endtask

    // ---------------- output monitor ----------------
    int    beat_cnt   = 0;
    int    done_cnt   = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_b;

    always @(negedge aclk_0) begin
        beat_t b, e;
        if (!aresetn_0) begin
            prev_stall = 1'b0;
        end else begin
            b = '{d: m_axis_tdata, last: m_axis_tlast, user: m_axis_tuser};
            if (prev_stall) check("stall_hold", {m_axis_tvalid, b}, {1'b1, prev_b});
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", b);
                end else begin
                    e = exp_q.pop_front();
                    check("m_beat", b, e);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_b     = b;
            if (frame_done) done_cnt++;
        end
    end

    // ---------------- vector table ----------------
    localparam int NV = 8;
    typedef struct {
        int         len;
        logic [7:0] b[16];
        logic       e_err;
        logic       e_runt;
        int         npay;
        logic       b2b;
    } vec_t;

    vec_t  tab[NV];
    string tab_name[NV];

    task automatic set_vec(input int i, input string nm, input int len, input logic [127:0] p,
                           input logic er, input logic rn, input int np, input logic b2b);
        tab_name[i]   = nm;
        tab[i].len    = len;
        for (int k = 0; k < 16; k++) tab[i].b[k] = 8'h00;
        for (int k = 0; k < len; k++) tab[i].b[k] = p[8*(len-1-k) +: 8];
        tab[i].e_err  = er;
        tab[i].e_runt = rn;
        tab[i].npay   = np;
        tab[i].b2b    = b2b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic d_done, d_err, d_runt, e_err, e_runt;
        logic [31:0] c;
        int b0, d0, plen, t;

        build_tab();
        set_vec(0, "good9",     13, 128'h3132333435363738392639F4CB, 1'b0, 1'b0, 9, 1'b0);
        set_vec(1, "bad9",      13, 128'h3132333435363738392639F4CA, 1'b1, 1'b0, 9, 1'b0);
        set_vec(2, "runt3",      3, 128'h0A0B0C,                     1'b0, 1'b1, 0, 1'b0);
        set_vec(3, "good9_b2b", 13, 128'h3132333435363738392639F4CB, 1'b0, 1'b0, 9, 1'b1);
        set_vec(4, "runt4",      4, 128'h01020304,                   1'b0, 1'b1, 0, 1'b0);
        set_vec(5, "runt1",      1, 128'h55,                         1'b0, 1'b1, 0, 1'b0);
        set_vec(6, "good_min",   5, 128'h6143BEB7E8,                 1'b0, 1'b0, 1, 1'b0);
        set_vec(7, "bad_min",    5, 128'h6143BEB7E9,                 1'b1, 1'b0, 1, 1'b0);

        aresetn_0     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        repeat (3) @(negedge aclk_0);
        check("rst_tready",  s_axis_tready, 0);
        check("rst_mvalid",  m_axis_tvalid, 0);
        check("rst_mlast",   m_axis_tlast, 0);
        check("rst_muser",   m_axis_tuser, 0);
        check("rst_done",    frame_done, 0);
        check("rst_crc_err", crc_err, 0);
        check("rst_runt",    runt, 0);
        check("rst_errcnt",  err_count, 0);
        @(posedge aclk_0); #1;
        aresetn_0 = 1'b1;
        @(posedge aclk_0); #1;
        check("tready_after_rst", s_axis_tready, 1);

        // Directed table, downstream always ready.
        b0 = beat_cnt;
        for (int i = 0; i < NV; i++) begin
            if (i > 0 && !tab[i].b2b) begin
                idle(1);
                check($sformatf("%s_errcnt", tab_name[i-1]), err_count, exp_cnt);
                check($sformatf("%s_errcnt2", tab_name[i-1]), err_count2, exp_cnt2);
            end
            if (i > 0) check($sformatf("%s_nbeats", tab_name[i-1]), beat_cnt - b0, tab[i-1].npay);
            flen = tab[i].len;
            for (int k = 0; k < flen; k++) fbuf[k] = tab[i].b[k];
            model_frame(e_err, e_runt);
            b0 = beat_cnt;
            send_frame(0, d_done, d_err, d_runt);
            check($sformatf("%s_done", tab_name[i]), d_done, 1);
            check($sformatf("%s_crc_err", tab_name[i]), d_err, tab[i].e_err);
            check($sformatf("%s_runt", tab_name[i]), d_runt, tab[i].e_runt);
            if (tab[i].npay > 0)
                check($sformatf("%s_last_beat", tab_name[i]),
                      {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata},
                      {1'b1, 1'b1, tab[i].e_err, 8'h39 & {8{tab[i].len == 13}} | 8'h61 & {8{tab[i].len == 5}}});
        end
        idle(1);
        check("table_nbeats", beat_cnt - b0, tab[NV-1].npay);
        check("table_errcnt", err_count, exp_cnt);
        check("table_errcnt2_sat", err_count2, 3);

        // Random good frames, random source gaps and downstream stalls.
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            plen = $urandom_range(1, 20);
            for (int j = 0; j < plen; j++) fbuf[j] = 8'($urandom);
            c = crc32_std(plen);
            for (int k = 0; k < 4; k++) fbuf[plen + k] = c[8*k +: 8];
            flen = plen + 4;
            model_frame(e_err, e_runt);
            send_frame(30, d_done, d_err, d_runt);
            check("rnd_done", d_done, 1);
            check("rnd_crc_err", d_err, e_err);
            check("rnd_runt", d_runt, e_runt);
        end
        rand_rdy = 1'b0;
        idle(1);
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin @(posedge aclk_0); #1; t++; end
        check("rnd_drain", exp_q.size(), 0);
        idle(2);
        check("rnd_errcnt", err_count, exp_cnt);

        // Reset in the middle of a frame.
        flen = 6;
        for (int j = 0; j < 6; j++) fbuf[j] = 8'($urandom);
        exp_q.push_back('{d: fbuf[0], last: 1'b0, user: 1'b0});
        exp_q.push_back('{d: fbuf[1], last: 1'b0, user: 1'b0});
        for (int j = 0; j < 6; j++) drive_byte(fbuf[j], 1'b0);
        idle(3);
        check("abort_partial_drained", exp_q.size(), 0);
        d0 = done_cnt;
        aresetn_0 = 1'b0;
        #1;
        check("midrst_tready", s_axis_tready, 0);
        check("midrst_mvalid", m_axis_tvalid, 0);
        @(posedge aclk_0); #1;
        aresetn_0 = 1'b1;
        exp_cnt   = 0;
        exp_cnt2  = 0;
        @(posedge aclk_0); #1;
        check("midrst_tready_back", s_axis_tready, 1);
        check("midrst_errcnt", err_count, 0);
        check("midrst_errcnt2", err_count2, 0);
        flen = 5;
        fbuf[0] = 8'h61; fbuf[1] = 8'h43; fbuf[2] = 8'hBE; fbuf[3] = 8'hB7; fbuf[4] = 8'hE8;
        model_frame(e_err, e_runt);
        send_frame(0, d_done, d_err, d_runt);
        check("post_rst_done", d_done, 1);
        check("post_rst_crc_err", d_err, 0);
        check("post_rst_last_beat", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata},
              {1'b1, 1'b1, 1'b0, 8'h61});
        idle(3);
        check("post_rst_done_count", done_cnt - d0, 1);
        check("total_frames", done_cnt, exp_frames);
        check("final_drain", exp_q.size(), 0);
        check("final_errcnt", err_count, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
